// File: rtl/dmem_port_arbiter_pkg.sv
// Shared encodings and defaults for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_CORE = 2'd1,
    RSP_LDR  = 2'd2
  } rsp_state_t;

  localparam int PORT_CORE = 0;
  localparam int PORT_LDR  = 1;

  localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Counts consecutive cycles the loader waits while valid, saturating at STARVE_LIMIT;
// force_l asks the arbiter to put the loader ahead of the core once the limit is reached.
module dmem_starve_ctr
  import dmem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       l_valid,
  input  logic       grant_l,
  output logic       force_l,
  output logic [3:0] wait_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  assign force_l = l_valid && (wait_cnt == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 4'd0;
    end else if (!l_valid || grant_l) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != LIMIT) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port data memory between the core MEM stage and the loader:
// core has fixed priority, a starvation guard forces periodic loader grants, reads respond one cycle later.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_valid,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_ready,
  output logic              c_rsp_valid,
  output logic [31:0]       c_rsp_rdata,
  input  logic              l_valid,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_ready,
  output logic              l_rsp_valid,
  output logic [31:0]       l_rsp_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              starve_evt
);

  logic       force_l;
  logic [3:0] wait_cnt;
  logic       grant_c;
  logic       grant_l;
  logic [1:0] grant;
  rsp_state_t rsp_state;

  dmem_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .l_valid (l_valid),
    .grant_l (grant_l),
    .force_l (force_l),
    .wait_cnt(wait_cnt)
  );

  assign grant_l = l_valid && (!c_valid || force_l);
  assign grant_c = c_valid && !grant_l;

  always_comb begin
    grant            = '0;
    grant[PORT_CORE] = grant_c;
    grant[PORT_LDR]  = grant_l;
  end

  assign c_ready = grant[PORT_CORE];
  assign l_ready = grant[PORT_LDR];

  // With no grant the core's fields still drive the memory; mem_we stays low then.
  assign mem_addr  = grant[PORT_LDR] ? 32'(l_addr) : 32'(c_addr);
  assign mem_wdata = grant[PORT_LDR] ? l_wdata : c_wdata;
  assign mem_we    = (grant[PORT_CORE] && c_we) || (grant[PORT_LDR] && l_we);

  // rsp_state names the port whose read data is presented this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_state   <= RSP_IDLE;
      c_rsp_rdata <= '0;
      l_rsp_rdata <= '0;
      starve_evt  <= 1'b0;
    end else begin
      starve_evt <= force_l && grant_l && c_valid;
      if (grant_c && !c_we) begin
        rsp_state   <= RSP_CORE;
        c_rsp_rdata <= mem_rdata;
      end else if (grant_l && !l_we) begin
        rsp_state   <= RSP_LDR;
        l_rsp_rdata <= mem_rdata;
      end else begin
        rsp_state <= RSP_IDLE;
      end
    end
  end

  assign c_rsp_valid = (rsp_state == RSP_CORE);
  assign l_rsp_valid = (rsp_state == RSP_LDR);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed and randomized checks of dmem_port_arbiter against a cycle-level model with its own memory image.
module tb_dmem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c_valid = 1'b0, c_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic        l_valid = 1'b0, l_we = 1'b0;
  logic [31:0] l_addr = '0, l_wdata = '0;
  logic        c_ready, c_rsp_valid, l_ready, l_rsp_valid;
  logic [31:0] c_rsp_rdata, l_rsp_rdata;
  logic        mem_we, starve_evt;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_port_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .c_valid(c_valid), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ready(c_ready), .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata),
    .l_valid(l_valid), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_ready(l_ready), .l_rsp_valid(l_rsp_valid), .l_rsp_rdata(l_rsp_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .starve_evt(starve_evt)
  );

  always #5 clk = ~clk;

  // The memory itself: 256 x 32, combinational read, write on the rising edge.
  logic [31:0] mem [256];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  function automatic logic [31:0] init_val(input int i);
    return (i == 8) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i) * 32'h0001_0003;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [31:0] ref_mem [256];
  int          streak;
  bit          pc, pl, pevt;
  logic [31:0] dc, dl;
  bit          gc, gl;
  bit          obs_l_ready, obs_evt;

  task automatic model_reset();
    streak = 0; pc = 0; pl = 0; pevt = 0; dc = '0; dl = '0;
  endtask

  // One bus cycle: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic tick();
    bit was_forced;
    @(negedge clk);
    was_forced = (streak >= LIMIT);
    gl = l_valid && (!c_valid || was_forced);
    gc = c_valid && !gl;
    obs_l_ready = l_ready;
    obs_evt     = starve_evt;
    chk("c_ready", 32'(c_ready), 32'(gc));
    chk("l_ready", 32'(l_ready), 32'(gl));
    chk("mem_we", 32'(mem_we), 32'((gc && c_we) || (gl && l_we)));
    chk("c_rsp_valid", 32'(c_rsp_valid), 32'(pc));
    chk("l_rsp_valid", 32'(l_rsp_valid), 32'(pl));
    chk("c_rsp_rdata", c_rsp_rdata, dc);
    chk("l_rsp_rdata", l_rsp_rdata, dl);
    chk("starve_evt", 32'(starve_evt), 32'(pevt));
    @(posedge clk);
    pevt = gl && c_valid && was_forced;
    pc = gc && !c_we;
    pl = gl && !l_we;
    if (pc) dc = ref_mem[c_addr[9:2]];
    if (pl) dl = ref_mem[l_addr[9:2]];
    if (gc && c_we) ref_mem[c_addr[9:2]] = c_wdata;
    if (gl && l_we) ref_mem[l_addr[9:2]] = l_wdata;
    if (gl || !l_valid) streak = 0;
    else if (streak < LIMIT) streak++;
    #1;
  endtask

  initial begin
    int evts;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    model_reset();

    // Reset held with both requesters valid
    c_valid = 1; l_valid = 1; c_we = 0; l_we = 0; c_addr = 32'h8; l_addr = 32'hC;
    #12;
    chk("rst_c_rsp_valid", 32'(c_rsp_valid), 32'd0);
    chk("rst_l_rsp_valid", 32'(l_rsp_valid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_wait_cnt", 32'(u_dut.wait_cnt), 32'd0);
    chk("rst_starve_evt", 32'(starve_evt), 32'd0);
    @(posedge clk); #1 rst_n = 1;
    tick();
    chk("first_grant_core", 32'(gc), 32'd1);
    c_valid = 0; l_valid = 0;
    tick();

    // Core write then read-after-write
    c_valid = 1; c_we = 1; c_addr = 32'h10; c_wdata = 32'hCAFEF00D;
    tick();
    c_we = 0;
    tick();
    c_valid = 0;
    tick();
    chk("raw_core_rdata", c_rsp_rdata, 32'hCAFEF00D);
    chk("raw_l_rsp_valid", 32'(l_rsp_valid), 32'd0);

    // Loader read with the core idle
    l_valid = 1; l_we = 0; l_addr = 32'h20;
    tick();
    chk("idle_l_ready", 32'(obs_l_ready), 32'd1);
    l_valid = 0;
    tick();
    chk("idle_l_rdata", l_rsp_rdata, 32'hDEADBEEF);

    // Same-cycle writes to one address
    c_valid = 1; c_we = 1; c_addr = 32'h40; c_wdata = 32'h1;
    l_valid = 1; l_we = 1; l_addr = 32'h40; l_wdata = 32'h2;
    tick();
    chk("cont_mem_core", mem[16], 32'h1);
    c_valid = 0;
    tick();
    chk("cont_mem_ldr", mem[16], 32'h2);
    l_valid = 0; c_valid = 1; c_we = 0; c_addr = 32'h40;
    tick();
    c_valid = 0;
    tick();
    chk("cont_readback", c_rsp_rdata, 32'h2);

    // Continuous contention: 4 core grants, then 1 forced loader grant
    c_valid = 1; c_we = 0; c_addr = 32'h0;
    l_valid = 1; l_we = 0; l_addr = 32'h4;
    evts = 0;
    for (int i = 0; i < 11; i++) begin
      tick();
      chk($sformatf("starve_pattern_%0d", i), 32'(obs_l_ready), 32'((i % 5) == 4));
      if (obs_evt) evts++;
    end
    chk("starve_evt_count", 32'(evts), 32'd2);
    c_valid = 0; l_valid = 0;
    tick();

    // Randomized traffic; requesters hold their request until accepted
    for (int n = 0; n < 1500; n++) begin
      if (!c_valid && ($urandom % 3) != 0) begin
        c_valid = 1; c_we = 1'($urandom % 2); c_wdata = $urandom;
        c_addr = ($urandom & 32'hFFFF_FC00) | (($urandom % 16) << 2) | ($urandom % 4);
      end
      if (!l_valid && ($urandom % 2) != 0) begin
        l_valid = 1; l_we = 1'($urandom % 2); l_wdata = $urandom;
        l_addr = ($urandom & 32'hFFFF_FC00) | (($urandom % 16) << 2) | ($urandom % 4);
      end
      tick();
      if (gc) c_valid = 0;
      if (gl) l_valid = 0;
    end
    c_valid = 0; l_valid = 0;
    tick();

    // Asynchronous reset between a read's acceptance and its response edge
    c_valid = 1; c_we = 0; c_addr = 32'h10;
    tick();
    c_addr = 32'h44;
    @(negedge clk); #1;
    chk("mid_rst_pre_valid", 32'(c_rsp_valid), 32'd1);
    rst_n = 0;
    #1;
    chk("mid_rst_drop", 32'(c_rsp_valid), 32'd0);
    chk("mid_rst_wait_cnt", 32'(u_dut.wait_cnt), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_no_rsp", 32'(c_rsp_valid), 32'd0);
    c_valid = 0;
    rst_n = 1;
    model_reset();
    tick();
    tick();
    // Memory survives the reset
    c_valid = 1; c_addr = 32'h10;
    tick();
    c_valid = 0;
    tick();
    chk("post_rst_mem", c_rsp_rdata, ref_mem[4]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
